// File: rtl/m_unit_pkg.sv
// Shared encodings and helpers for the M-extension sequencer (m_unit_ctrl) and
// its divide special-case detector.
package m_unit_pkg;

    localparam int M_XLEN = 32;

    typedef logic [2:0] m_op_t;

    localparam m_op_t OP_MUL    = 3'd0;
    localparam m_op_t OP_MULH   = 3'd1;
    localparam m_op_t OP_MULHSU = 3'd2;
    localparam m_op_t OP_MULHU  = 3'd3;
    localparam m_op_t OP_DIV    = 3'd4;
    localparam m_op_t OP_DIVU   = 3'd5;
    localparam m_op_t OP_REM    = 3'd6;
    localparam m_op_t OP_REMU   = 3'd7;

    typedef logic [2:0] m_state_t;

    localparam m_state_t S_IDLE      = 3'd0;
    localparam m_state_t S_MUL_WAIT  = 3'd1;
    localparam m_state_t S_DIV_WAIT  = 3'd2;
    localparam m_state_t S_DIV_DRAIN = 3'd3;
    localparam m_state_t S_DONE      = 3'd4;

    localparam logic [M_XLEN-1:0] DIV_ZERO_QUOT = '1;
    localparam logic [M_XLEN-1:0] INT_MIN       = {1'b1, {(M_XLEN-1){1'b0}}};

    function automatic logic op_is_div(input m_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input m_op_t op);
        return op[2] & op[1];
    endfunction

    // Only meaningful for divide ops: DIV and REM are the even encodings.
    function automatic logic op_is_signed(input m_op_t op);
        return ~op[0];
    endfunction

    function automatic logic [1:0] op_mul_sign(input m_op_t op);
        logic [1:0] sg;
        case (op)
            OP_MULHSU: sg = 2'b10;
            OP_MULHU:  sg = 2'b00;
            default:   sg = 2'b11;
        endcase
        return sg;
    endfunction

endpackage

// File: rtl/m_div_special.sv
// Combinational detection of divide-by-zero and signed overflow, with the
// architecturally defined result so the divider need not be started.
module m_div_special
    import m_unit_pkg::*;
#(
    parameter int XLEN = M_XLEN
)(
    input  logic [2:0]      op_code,
    input  logic [XLEN-1:0] s1,
    input  logic [XLEN-1:0] s2,
    output logic            is_special,
    output logic [XLEN-1:0] special_result
);

    localparam logic [XLEN-1:0] ALL_ONES = (XLEN == M_XLEN) ? XLEN'(DIV_ZERO_QUOT) : {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_VAL  = (XLEN == M_XLEN) ? XLEN'(INT_MIN)
                                                            : {1'b1, {(XLEN-1){1'b0}}};

    logic div_by_zero;
    logic overflow;

    always_comb begin
        div_by_zero    = (s2 == '0);
        overflow       = op_is_signed(op_code) && (s1 == MIN_VAL) && (s2 == ALL_ONES);
        is_special     = op_is_div(op_code) && (div_by_zero || overflow);
        special_result = '0;
        if (div_by_zero) begin
            special_result = op_is_rem(op_code) ? s1 : ALL_ONES;
        end else if (overflow) begin
            special_result = op_is_rem(op_code) ? '0 : MIN_VAL;
        end
    end

endmodule

// File: rtl/m_unit_ctrl.sv
// M-extension sequencer: issues to the pipelined multiplier or iterative divider and
// stalls EX until the result pulse. Define M_DIV_CACHE_EN for a last-result divide cache.
module m_unit_ctrl
    import m_unit_pkg::*;
#(
    parameter int XLEN    = M_XLEN,
    parameter int MUL_LAT = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [XLEN-1:0]   op_s1,
    input  logic [XLEN-1:0]   op_s2,
    input  logic              flush,
    output logic              stall,
    output logic              res_valid,
    output logic [XLEN-1:0]   res_data,
    output logic              mul_valid,
    output logic [XLEN-1:0]   mul_s1,
    output logic [XLEN-1:0]   mul_s2,
    output logic [1:0]        mul_sign,
    input  logic [2*XLEN-1:0] mul_result,
    output logic              div_start,
    output logic [XLEN:0]     div_s1,
    output logic [XLEN:0]     div_s2,
    input  logic              div_done,
    input  logic [XLEN:0]     div_quotient,
    input  logic [XLEN:0]     div_remainder
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    m_state_t         state;
    m_op_t            op_q;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             spec_hit;
    logic [XLEN-1:0]  spec_result;
    logic             cache_hit;
    logic [XLEN-1:0]  cache_result;
    logic [XLEN-1:0]  div_pick;
    logic             div_sext;
    logic             unused_div_msb;

    assign accept    = (state == S_IDLE) && op_valid && !flush;
    assign stall     = accept || (state == S_MUL_WAIT) || (state == S_DIV_WAIT);
    assign res_valid = (state == S_DONE) && !flush;
    assign div_sext  = op_is_signed(op_code);
    assign div_pick  = op_is_rem(op_q) ? div_remainder[XLEN-1:0] : div_quotient[XLEN-1:0];

    // The extension bit of the divider outputs never reaches the architectural result.
    assign unused_div_msb = ^{div_quotient[XLEN], div_remainder[XLEN]};

    m_div_special #(.XLEN(XLEN)) u_special (
        .op_code        (op_code),
        .s1             (op_s1),
        .s2             (op_s2),
        .is_special     (spec_hit),
        .special_result (spec_result)
    );

`ifdef M_DIV_CACHE_EN
    logic            cache_valid;
    logic            cache_signed;
    logic [XLEN-1:0] cache_s1;
    logic [XLEN-1:0] cache_s2;
    logic [XLEN-1:0] cache_quot;
    logic [XLEN-1:0] cache_rem;

    assign cache_hit = cache_valid && op_is_div(op_code)
                    && (cache_signed == op_is_signed(op_code))
                    && (cache_s1 == op_s1) && (cache_s2 == op_s2);
    assign cache_result = op_is_rem(op_code) ? cache_rem : cache_quot;

    // Filled only by a divide that completes normally; a drained divide is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid  <= 1'b0;
            cache_signed <= 1'b0;
            cache_s1     <= '0;
            cache_s2     <= '0;
            cache_quot   <= '0;
            cache_rem    <= '0;
        end else if ((state == S_DIV_WAIT) && div_done && !flush) begin
            cache_valid  <= 1'b1;
            cache_signed <= op_is_signed(op_q);
            cache_s1     <= div_s1[XLEN-1:0];
            cache_s2     <= div_s2[XLEN-1:0];
            cache_quot   <= div_quotient[XLEN-1:0];
            cache_rem    <= div_remainder[XLEN-1:0];
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    // Operands and the divider/multiplier issue signals stay registered so they are
    // stable for the whole op; the issue strobes self-clear after one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_MUL;
            cnt       <= '0;
            res_data  <= '0;
            mul_valid <= 1'b0;
            mul_s1    <= '0;
            mul_s2    <= '0;
            mul_sign  <= 2'b00;
            div_start <= 1'b0;
            div_s1    <= '0;
            div_s2    <= '0;
        end else begin
            mul_valid <= 1'b0;
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= op_code;
                        if (!op_is_div(op_code)) begin
                            mul_valid <= 1'b1;
                            mul_s1    <= op_s1;
                            mul_s2    <= op_s2;
                            mul_sign  <= op_mul_sign(op_code);
                            cnt       <= CNT_W'(1);
                            state     <= S_MUL_WAIT;
                        end else if (spec_hit) begin
                            res_data <= spec_result;
                            state    <= S_DONE;
                        end else if (cache_hit) begin
                            res_data <= cache_result;
                            state    <= S_DONE;
                        end else begin
                            div_start <= 1'b1;
                            div_s1    <= {div_sext & op_s1[XLEN-1], op_s1};
                            div_s2    <= {div_sext & op_s2[XLEN-1], op_s2};
                            state     <= S_DIV_WAIT;
                        end
                    end
                end
                S_MUL_WAIT: begin
                    if (flush) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (cnt == CNT_W'(MUL_LAT)) begin
                        res_data <= (op_q == OP_MUL) ? mul_result[XLEN-1:0]
                                                     : mul_result[2*XLEN-1:XLEN];
                        cnt      <= '0;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DIV_WAIT: begin
                    // A flush coinciding with completion has nothing left to drain.
                    if (div_done) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            res_data <= div_pick;
                            state    <= S_DONE;
                        end
                    end else if (flush) begin
                        state <= S_DIV_DRAIN;
                    end
                end
                S_DIV_DRAIN: begin
                    if (div_done) begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_unit_ctrl.sv
// Directed self-checking bench for m_unit_ctrl with behavioural multiplier and divider
// models; expectations adapt when M_DIV_CACHE_EN is defined.
module tb_m_unit_ctrl;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

`ifdef M_DIV_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              op_valid;
    logic [2:0]        op_code;
    logic [XLEN-1:0]   op_s1;
    logic [XLEN-1:0]   op_s2;
    logic              flush;
    logic              stall;
    logic              res_valid;
    logic [XLEN-1:0]   res_data;
    logic              mul_valid;
    logic [XLEN-1:0]   mul_s1;
    logic [XLEN-1:0]   mul_s2;
    logic [1:0]        mul_sign;
    logic [2*XLEN-1:0] mul_result = '0;
    logic              div_start;
    logic [XLEN:0]     div_s1;
    logic [XLEN:0]     div_s2;
    logic              div_done = 1'b0;
    logic [XLEN:0]     div_quotient = '0;
    logic [XLEN:0]     div_remainder = '0;

    int n_checks = 0;
    int n_fail   = 0;

    int          lat;
    int          starts;
    int          muls;
    int          bad;
    logic        stall_t;
    logic [32:0] s1_seen;

    m_unit_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_code       (op_code),
        .op_s1         (op_s1),
        .op_s2         (op_s2),
        .flush         (flush),
        .stall         (stall),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .mul_valid     (mul_valid),
        .mul_s1        (mul_s1),
        .mul_s2        (mul_s2),
        .mul_sign      (mul_sign),
        .mul_result    (mul_result),
        .div_start     (div_start),
        .div_s1        (div_s1),
        .div_s2        (div_s2),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    // Multiplier model: product visible for exactly one cycle, MUL_LAT-1 cycles after
    // the issue cycle; any other cycle shows a junk pattern.
    function automatic logic [63:0] mulModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] sg);
        logic signed [64:0] ea;
        logic signed [64:0] eb;
        logic signed [64:0] p;
        ea = sg[1] ? {{33{a[31]}}, a} : {33'd0, a};
        eb = sg[0] ? {{33{b[31]}}, b} : {33'd0, b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    logic        mul_pend_v = 1'b0;
    logic [63:0] mul_pend   = '0;

    always @(negedge clk) begin
        mul_result = mul_pend_v ? mul_pend : 64'hDEAD_BEEF_DEAD_BEEF;
        mul_pend_v = mul_valid;
        mul_pend   = mulModel(mul_s1, mul_s2, mul_sign);
    end

    // Divider model: 33-bit signed divide, done pulse div_lat cycles after the start
    // cycle; cleared by the same rst as the controller.
    int                 div_lat  = 33;
    int                 div_left = 0;
    logic               div_rst_q = 1'b1;
    logic signed [32:0] dq;
    logic signed [32:0] dr;

    always @(posedge clk) div_rst_q <= rst;

    always @(negedge clk) begin
        if (div_rst_q) begin
            div_left = 0;
            div_done = 1'b0;
        end else begin
            div_done = 1'b0;
            if (div_left > 0) begin
                div_left--;
                if (div_left == 0) div_done = 1'b1;
            end
            if (div_start) begin
                div_left = div_lat;
                if (div_s2 != '0) begin
                    dq = $signed(div_s1) / $signed(div_s2);
                    dr = $signed(div_s1) % $signed(div_s2);
                end else begin
                    dq = '1;
                    dr = div_s1;
                end
                div_quotient  = dq;
                div_remainder = dr;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents one op for a single cycle, then waits (bounded) for the result pulse.
    // lat is the result cycle relative to the accept cycle, -1 on timeout.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output int l, output int ns,
                                 output int nm, output logic st, output logic [32:0] s1s);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = op;
        op_s1    = a;
        op_s2    = b;
        #1;
        st  = stall;
        l   = -1;
        ns  = 0;
        nm  = 0;
        s1s = '0;
        for (int k = 1; k <= 200 && l < 0; k++) begin
            @(negedge clk);
            op_valid = 1'b0;
            #1;
            if (div_start) begin
                ns++;
                s1s = div_s1;
            end
            if (mul_valid) nm++;
            if (res_valid) l = k;
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = '0;
        op_s1    = '0;
        op_s2    = '0;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset res_valid", 64'(res_valid), 0);
        checkOutput("reset res_data", 64'(res_data), 0);
        checkOutput("reset mul_valid", 64'(mul_valid), 0);
        checkOutput("reset mul_sign", 64'(mul_sign), 0);
        checkOutput("reset div_start", 64'(div_start), 0);
        checkOutput("reset div_s1", 64'(div_s1), 0);
        checkOutput("reset stall", 64'(stall), 0);
        @(negedge clk);
        rst = 1'b0;

        // MULH -2 x 3, cycle by cycle
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MULH; op_s1 = 'hFFFF_FFFE; op_s2 = 3;
        #1;
        checkOutput("mulh stall T", 64'(stall), 1);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        checkOutput("mulh mul_valid T+1", 64'(mul_valid), 1);
        checkOutput("mulh mul_sign", 64'(mul_sign), 3);
        checkOutput("mulh mul_s1", 64'(mul_s1), 'hFFFF_FFFE);
        checkOutput("mulh stall T+1", 64'(stall), 1);
        @(negedge clk);
        #1;
        checkOutput("mulh mul_valid T+2", 64'(mul_valid), 0);
        checkOutput("mulh stall T+2", 64'(stall), 1);
        checkOutput("mulh res_valid T+2", 64'(res_valid), 0);
        @(negedge clk);
        #1;
        checkOutput("mulh res_valid T+3", 64'(res_valid), 1);
        checkOutput("mulh res_data", 64'(res_data), 'hFFFF_FFFF);
        checkOutput("mulh stall T+3", 64'(stall), 0);
        @(negedge clk);
        #1;
        checkOutput("mulh res_valid T+4", 64'(res_valid), 0);
        checkOutput("mulh res_data hold", 64'(res_data), 'hFFFF_FFFF);

        // Divider path and divide special cases
        applyStimulus(OP_DIVU, 100, 7, lat, starts, muls, stall_t, s1_seen);
        checkOutput("divu stall T", 64'(stall_t), 1);
        checkOutput("divu latency", 64'(lat), 35);
        checkOutput("divu starts", 64'(starts), 1);
        checkOutput("divu div_s1", 64'(s1_seen), 'h0_0000_0064);
        checkOutput("divu result", 64'(res_data), 14);

        applyStimulus(OP_REMU, 100, 7, lat, starts, muls, stall_t, s1_seen);
        checkOutput("remu latency", 64'(lat), CACHE_ON ? 1 : 35);
        checkOutput("remu starts", 64'(starts), CACHE_ON ? 0 : 1);
        checkOutput("remu result", 64'(res_data), 2);

        applyStimulus(OP_DIV, 5, 0, lat, starts, muls, stall_t, s1_seen);
        checkOutput("div0 latency", 64'(lat), 1);
        checkOutput("div0 starts", 64'(starts), 0);
        checkOutput("div0 result", 64'(res_data), 'hFFFF_FFFF);

        applyStimulus(OP_REM, 'h8000_0000, 'hFFFF_FFFF, lat, starts, muls, stall_t, s1_seen);
        checkOutput("rem ovf latency", 64'(lat), 1);
        checkOutput("rem ovf starts", 64'(starts), 0);
        checkOutput("rem ovf result", 64'(res_data), 0);

        applyStimulus(OP_DIV, 'h8000_0000, 'hFFFF_FFFF, lat, starts, muls, stall_t, s1_seen);
        checkOutput("div ovf result", 64'(res_data), 'h8000_0000);

        applyStimulus(OP_REMU, 9, 0, lat, starts, muls, stall_t, s1_seen);
        checkOutput("remu0 result", 64'(res_data), 9);

        // Unsigned high half and plain low half
        applyStimulus(OP_MULHU, 'hFFFF_FFFE, 3, lat, starts, muls, stall_t, s1_seen);
        checkOutput("mulhu latency", 64'(lat), 3);
        checkOutput("mulhu issues", 64'(muls), 1);
        checkOutput("mulhu result", 64'(res_data), 2);

        applyStimulus(OP_MUL, 'hFFFF_FFFE, 3, lat, starts, muls, stall_t, s1_seen);
        checkOutput("mul result", 64'(res_data), 'hFFFF_FFFA);

        // Flush while idle: nothing accepted
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MUL; op_s1 = 6; op_s2 = 7; flush = 1'b1;
        #1;
        checkOutput("idle flush stall", 64'(stall), 0);
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        checkOutput("idle flush mul_valid", 64'(mul_valid), 0);

        // Flush in MUL_WAIT: late product ignored, next op clean
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MUL; op_s1 = 6; op_s2 = 7;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (res_valid || stall) bad++;
            @(negedge clk);
        end
        checkOutput("mul flush quiet cycles", 64'(bad), 0);
        applyStimulus(OP_MUL, 5, 5, lat, starts, muls, stall_t, s1_seen);
        checkOutput("mul after flush latency", 64'(lat), 3);
        checkOutput("mul after flush result", 64'(res_data), 25);

        // Flush in DIV_WAIT, divider finishes 18 cycles later; MUL waits out the drain
        div_lat = 20;
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIVU; op_s1 = 1000; op_s2 = 7;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        checkOutput("drain div_start", 64'(div_start), 1);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("drain stall at flush", 64'(stall), 1);
        @(negedge clk);
        flush = 1'b0;
        op_valid = 1'b1; op_code = OP_MUL; op_s1 = 6; op_s2 = 7;
        bad = 0;
        for (int k = 4; k <= 21; k++) begin
            if (k > 4) @(negedge clk);
            #1;
            if (stall || res_valid || mul_valid) bad++;
        end
        checkOutput("drain quiet cycles", 64'(bad), 0);
        @(negedge clk);
        #1;
        checkOutput("drain then accept stall", 64'(stall), 1);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        checkOutput("drain then mul_valid", 64'(mul_valid), 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("drain then res_valid", 64'(res_valid), 1);
        checkOutput("drain then result", 64'(res_data), 42);
        div_lat = 33;

        // Flush in DONE suppresses the pulse
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIVU; op_s1 = 5; op_s2 = 0;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b1;
        #1;
        checkOutput("done flush res_valid", 64'(res_valid), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("done flush after", 64'(res_valid), 0);

        // Back-to-back MUL then DIV with op_valid held high
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MUL; op_s1 = 6; op_s2 = 7;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("b2b mul res_valid", 64'(res_valid), 1);
        checkOutput("b2b mul result", 64'(res_data), 42);
        checkOutput("b2b done stall", 64'(stall), 0);
        @(negedge clk);
        op_code = OP_DIV; op_s1 = 'hFFFF_FFEC; op_s2 = 3;
        #1;
        checkOutput("b2b div accept stall", 64'(stall), 1);
        lat = -1; starts = 0; s1_seen = '0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            #1;
            if (div_start) begin
                starts++;
                s1_seen = div_s1;
            end
            if (res_valid) begin
                lat = k;
                op_valid = 1'b0;
            end
        end
        op_valid = 1'b0;
        checkOutput("b2b div latency", 64'(lat), 35);
        checkOutput("b2b div starts", 64'(starts), 1);
        checkOutput("b2b div sext s1", 64'(s1_seen), 'h1_FFFF_FFEC);
        checkOutput("b2b div result", 64'(res_data), 'hFFFF_FFFA);

        applyStimulus(OP_REM, 'hFFFF_FFEC, 3, lat, starts, muls, stall_t, s1_seen);
        checkOutput("rem cache latency", 64'(lat), CACHE_ON ? 1 : 35);
        checkOutput("rem cache starts", 64'(starts), CACHE_ON ? 0 : 1);
        checkOutput("rem cache result", 64'(res_data), 'hFFFF_FFFE);

        // Reset in the middle of a divide
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIVU; op_s1 = 12345; op_s2 = 7;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst stall", 64'(stall), 0);
        checkOutput("midrst div_s1", 64'(div_s1), 0);
        checkOutput("midrst res_data", 64'(res_data), 0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (res_valid) bad++;
        end
        checkOutput("midrst no result", 64'(bad), 0);

        applyStimulus(OP_REM, 'hFFFF_FFEC, 3, lat, starts, muls, stall_t, s1_seen);
        checkOutput("rem post-rst latency", 64'(lat), 35);
        checkOutput("rem post-rst starts", 64'(starts), 1);
        checkOutput("rem post-rst result", 64'(res_data), 'hFFFF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
